// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshakes and tag pass-through.
// Define ALU_MUL_EN to enable the iterative shift-add MUL (op 10); otherwise op 10 is illegal.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [TAG_W-1:0] out_tag,
    output logic             Carry,
    output logic             OverFlow,
    output logic             Zero,
    output logic             Negative,
    output logic             Err
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             out_free;
    logic             accept;
    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic             load;
    logic [WIDTH-1:0] ld_res;
    logic [TAG_W-1:0] ld_tag;
    logic             ld_carry;
    logic             ld_ovf;
    logic             ld_err;

    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Every op except ADD uses the subtractor, so SLT/SLTU share the A-B flags.
    assign sub_op = (ALUControl != 4'd0);
    assign b_eff  = sub_op ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign ovf    = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign shamt  = B[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (ALUControl)
            4'd0, 4'd1: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = ovf;
            end
            4'd2:    alu_res = A & B;
            4'd3:    alu_res = A | B;
            4'd4:    alu_res = A ^ B;
            4'd5:    alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            4'd7:    alu_res = A << shamt;
            4'd8:    alu_res = A >> shamt;
            4'd9:    alu_res = $unsigned($signed(A) >>> shamt);
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

    state_e           state;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [TAG_W-1:0] mul_tag;
    logic             mul_op;
    logic             mul_done;

    assign mul_op   = (ALUControl == 4'd10);
    assign mul_done = (state == StMulBusy) && (cnt == (SHW+1)'(WIDTH));
    assign in_ready = (state == StIdle) && out_free;
    // A finished MUL holds in StMulBusy until the output register is free.
    assign load     = out_free && (mul_done || (accept && !mul_op));
    assign ld_res   = mul_done ? acc : alu_res;
    assign ld_tag   = mul_done ? mul_tag : in_tag;
    assign ld_carry = mul_done ? 1'b0 : alu_carry;
    assign ld_ovf   = mul_done ? 1'b0 : alu_ovf;
    assign ld_err   = mul_done ? 1'b0 : alu_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_tag <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept && mul_op) begin
                        state   <= StMulBusy;
                        cnt     <= '0;
                        acc     <= '0;
                        mcand   <= A;
                        mplier  <= B;
                        mul_tag <= in_tag;
                    end
                end
                StMulBusy: begin
                    if (!mul_done) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + (SHW+1)'(1);
                    end else if (out_free) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
`else
    assign in_ready = out_free;
    assign load     = accept;
    assign ld_res   = alu_res;
    assign ld_tag   = in_tag;
    assign ld_carry = alu_carry;
    assign ld_ovf   = alu_ovf;
    assign ld_err   = alu_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            Result    <= '0;
            out_tag   <= '0;
            Carry     <= 1'b0;
            OverFlow  <= 1'b0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Err       <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            Result    <= ld_res;
            out_tag   <= ld_tag;
            Carry     <= ld_carry;
            OverFlow  <= ld_ovf;
            Zero      <= (ld_res == '0);
            Negative  <= ld_res[WIDTH-1];
            Err       <= ld_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): directed vectors, monitor pops and compares results.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [4:0]  out_tag;
    logic        Carry, OverFlow, Zero, Negative, Err;

    alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .out_tag    (out_tag),
        .Carry      (Carry),
        .OverFlow   (OverFlow),
        .Zero       (Zero),
        .Negative   (Negative),
        .Err        (Err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] t,
                                input logic c, input logic v, input logic e);
        exp_t x;
        x.res = r;
        x.tag = t;
        x.c   = c;
        x.v   = v;
        x.z   = (r == 32'd0);
        x.n   = r[31];
        x.e   = e;
        return x;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input exp_t e, output int stall);
        stall      = 0;
        ALUControl = op;
        A          = a;
        B          = b;
        in_tag     = tag;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && stall < 200) begin
            stall++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout tag%0d: in_ready=0, expected 1 within 200 cycles", tag);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_result: got tag %0d result 0x%08h, expected none",
                             out_tag, Result);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result tag%0d", e.tag), Result, e.res);
                    chk($sformatf("out_tag tag%0d", e.tag), 32'(out_tag), 32'(e.tag));
                    chk($sformatf("carry tag%0d", e.tag), 32'(Carry), 32'(e.c));
                    chk($sformatf("overflow tag%0d", e.tag), 32'(OverFlow), 32'(e.v));
                    chk($sformatf("zero tag%0d", e.tag), 32'(Zero), 32'(e.z));
                    chk($sformatf("negative tag%0d", e.tag), 32'(Negative), 32'(e.n));
                    chk($sformatf("err tag%0d", e.tag), 32'(Err), 32'(e.e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        ALUControl = '0;
        in_tag     = '0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", Result, 32'd0);
        chk("reset out_tag", 32'(out_tag), 32'd0);
        chk("reset flags", 32'({Carry, OverFlow, Zero, Negative, Err}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after release", 32'(in_ready), 32'd1);

        // Single-cycle ops
        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd1, mk(32'h8000_0000, 5'd1, 1'b0, 1'b1, 1'b0), st);
        chk("add latency 1", 32'(out_valid), 32'd1);
        issue(4'd1, 32'd5, 32'd5, 5'd2, mk(32'h0, 5'd2, 1'b1, 1'b0, 1'b0), st);
        issue(4'd5, 32'h8000_0000, 32'h1, 5'd3, mk(32'h1, 5'd3, 1'b0, 1'b0, 1'b0), st);
        issue(4'd6, 32'h8000_0000, 32'h1, 5'd4, mk(32'h0, 5'd4, 1'b0, 1'b0, 1'b0), st);
        issue(4'd9, 32'h8000_0000, 32'h21, 5'd5, mk(32'hC000_0000, 5'd5, 1'b0, 1'b0, 1'b0), st);
        issue(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, mk(32'h00F0_00F0, 5'd6, 0, 0, 0), st);
        issue(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7, mk(32'hFFF0_FFF0, 5'd7, 0, 0, 0), st);
        issue(4'd7, 32'h1, 32'hFFFF_FF1F, 5'd8, mk(32'h8000_0000, 5'd8, 0, 0, 0), st);
        issue(4'd8, 32'h8000_0000, 32'h24, 5'd9, mk(32'h0800_0000, 5'd9, 0, 0, 0), st);
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd10, mk(32'h0, 5'd10, 1'b1, 1'b0, 1'b0), st);
        issue(4'd1, 32'h0, 32'h1, 5'd11, mk(32'hFFFF_FFFF, 5'd11, 1'b0, 1'b0, 1'b0), st);
        issue(4'd1, 32'h8000_0000, 32'h1, 5'd12, mk(32'h7FFF_FFFF, 5'd12, 1'b1, 1'b1, 1'b0), st);
        issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, mk(32'h0, 5'd13, 0, 0, 1'b1), st);
        wait_idle();

        // Back-to-back ADDs
        for (int i = 0; i < 8; i++) begin
            issue(4'd0, 32'(i * 16), 32'(i + 1), 5'(16 + i),
                  mk(32'(i * 16 + i + 1), 5'(16 + i), 1'b0, 1'b0, 1'b0), st);
            chk($sformatf("b2b stall %0d", i), 32'(st), 32'd0);
            chk($sformatf("b2b out_valid %0d", i), 32'(out_valid), 32'd1);
        end
        wait_idle();

        // Output back-pressure
        out_ready = 1'b0;
        issue(4'd4, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd24, mk(32'hA5A5_5A5A, 5'd24, 0, 0, 0), st);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold in_ready %0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("hold out_valid %0d", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold result %0d", k), Result, 32'hA5A5_5A5A);
            chk($sformatf("hold out_tag %0d", k), 32'(out_tag), 32'd24);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(4'd0, 32'd100, 32'd23, 5'd25, mk(32'd123, 5'd25, 0, 0, 0), st);
        chk("accept on drain stall", 32'(st), 32'd0);
        wait_idle();

        // MUL
`ifdef ALU_MUL_EN
        issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 5'd26, mk(32'hFFFF_FFFF, 5'd26, 0, 0, 0), st);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mul busy out_valid c%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("mul busy in_ready c%0d", k), 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("mul out_valid at 33", 32'(out_valid), 32'd1);
`else
        issue(4'd10, 32'h0000_FFFF, 32'h0001_0001, 5'd26, mk(32'h0, 5'd26, 0, 0, 1'b1), st);
        chk("mul illegal latency 1", 32'(out_valid), 32'd1);
`endif
        wait_idle();

        // Reset with an operation in flight; its result must never appear
`ifndef ALU_MUL_EN
        out_ready = 1'b0;
`endif
        ALUControl = 4'd10;
        A          = 32'h1234_5678;
        B          = 32'h0000_0003;
        in_tag     = 5'd27;
        in_valid   = 1'b1;
        @(negedge clk);
        chk("inflight accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midop rst out_valid", 32'(out_valid), 32'd0);
        chk("midop rst result", Result, 32'd0);
        chk("midop rst out_tag", 32'(out_tag), 32'd0);
        chk("midop rst flags", 32'({Carry, OverFlow, Zero, Negative, Err}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after midop rst", 32'(in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;

        issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, mk(32'h0, 5'd30, 0, 0, 1'b1), st);
        wait_idle();
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
